// File: rtl/pipelined_adder_subtractor.sv
// pipelined_adder_subtractor: WIDTH-bit add/sub, carry chain split over STAGES registered segments.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, A, B, Op (0 add, 1 sub);
//        out_valid/out_ready, S result, C carry-out (sub: 1 = no borrow), V signed overflow, Z zero.
// Optional: define ADDSUB_SATURATE_EN to clamp S to signed max/min on overflow.
module pipelined_adder_subtractor #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             V,
   output logic             Z
);
   localparam int SEG = WIDTH / STAGES;
   localparam int L   = STAGES - 1;
   generate
      if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
         $error("pipelined_adder_subtractor: illegal WIDTH/STAGES combination");
      end
   endgenerate
   logic             vld    [STAGES];
   logic             vld_in [STAGES];
   logic             c_q    [STAGES];
   logic             c_in   [STAGES];
   logic             c_nx   [STAGES];
   logic [WIDTH-1:0] a_q    [STAGES];
   logic [WIDTH-1:0] b_q    [STAGES];
   logic [WIDTH-1:0] s_q    [STAGES];
   logic [WIDTH-1:0] a_in   [STAGES];
   logic [WIDTH-1:0] b_in   [STAGES];
   logic [WIDTH-1:0] s_in   [STAGES];
   logic [WIDTH-1:0] s_nx   [STAGES];
   logic [SEG:0]     seg    [STAGES];
   logic             adv;
   logic             v_nx;
   logic             v_q;
   logic             z_q;
   logic [WIDTH-1:0] s_fin;
   assign adv       = !vld[L] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld[L];
   assign S         = s_q[L];
   assign C         = c_q[L];
   assign V         = v_q;
   assign Z         = z_q;
   // B is inverted once at entry; the upper operand bits then ride along already conditioned.
   always_comb begin
      a_in[0]   = A;
      b_in[0]   = B ^ {WIDTH{Op}};
      s_in[0]   = '0;
      c_in[0]   = Op;
      vld_in[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k]   = a_q[k-1];
         b_in[k]   = b_q[k-1];
         s_in[k]   = s_q[k-1];
         c_in[k]   = c_q[k-1];
         vld_in[k] = vld[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         seg[k]                = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]} + {{SEG{1'b0}}, c_in[k]};
         s_nx[k]               = s_in[k];
         s_nx[k][k*SEG +: SEG] = seg[k][SEG-1:0];
         c_nx[k]               = seg[k][SEG];
      end
      // carry into the MSB is recovered from the MSB sum bit: s ^ a ^ b
      v_nx = s_nx[L][WIDTH-1] ^ a_in[L][WIDTH-1] ^ b_in[L][WIDTH-1] ^ c_nx[L];
`ifdef ADDSUB_SATURATE_EN
      // overflow always has the sign of A, so A's MSB picks the clamp direction
      s_fin = v_nx ? (a_in[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : s_nx[L];
`else
      s_fin = s_nx[L];
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            vld[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
         v_q <= 1'b0;
         z_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            vld[k] <= vld_in[k];
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            s_q[k] <= (k == L) ? s_fin : s_nx[k];
            c_q[k] <= c_nx[k];
         end
         v_q <= v_nx;
         z_q <= (s_fin == '0);
      end
   end
endmodule
